// File: rtl/counter_run_ctrl.sv
// rtl/counter_run_ctrl.sv - command sequencer driving an external 8-bit up/down counter
//
// Purpose: accepts run commands (direction, step count, optional pre-clear) and drives
// the counter's CE / UpDown / synchronous-clear pins, reporting progress and completion.
// Optional feature macro: COUNTER_RUN_CTRL_SAT_EN adds a saturation guard and sat_hit_o.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o command handshake (ready only in IDLE)
//   cmd_dir_i, cmd_len_i, cmd_clr_i  command fields (1=up, step count, pre-clear)
//   abort_i                terminate the current run
//   cnt_value_i            current counter value (used by the saturation guard)
//   cnt_ce_o, cnt_updown_o, cnt_clear_o  counter control pins
//   busy_o, done_o, steps_done_o, aborted_o  status
//   sat_hit_o              run ended by saturation guard (macro builds only)
module counter_run_ctrl (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic       cmd_dir_i,
   input  logic [7:0] cmd_len_i,
   input  logic       cmd_clr_i,
   input  logic       abort_i,
   input  logic [7:0] cnt_value_i,
   output logic       cnt_ce_o,
   output logic       cnt_updown_o,
   output logic       cnt_clear_o,
   output logic       busy_o,
   output logic       done_o,
   output logic [7:0] steps_done_o,
   output logic       aborted_o
`ifdef COUNTER_RUN_CTRL_SAT_EN
   ,
   output logic       sat_hit_o
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] len_q, len_d;
   logic [7:0] steps_q, steps_d;
   logic       aborted_q, aborted_d;
   // Direction is stored inverted so every latched field resets to 0 while the
   // UpDown pin still comes out of reset as 1 (count up).
   logic       dir_n_q, dir_n_d;
   logic [7:0] steps_inc;

   assign steps_inc = steps_q + 8'd1;

`ifdef COUNTER_RUN_CTRL_SAT_EN
   logic sat_q, sat_d;
   logic sat_now;
   // The next CE would wrap the counter past its end stop.
   assign sat_now = (!dir_n_q && (cnt_value_i == 8'hFF)) ||
                    ( dir_n_q && (cnt_value_i == 8'h00));
`else
   logic unused_cnt_value;
   assign unused_cnt_value = ^cnt_value_i;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         len_q     <= 8'd0;
         steps_q   <= 8'd0;
         aborted_q <= 1'b0;
         dir_n_q   <= 1'b0;
`ifdef COUNTER_RUN_CTRL_SAT_EN
         sat_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         steps_q   <= steps_d;
         aborted_q <= aborted_d;
         dir_n_q   <= dir_n_d;
`ifdef COUNTER_RUN_CTRL_SAT_EN
         sat_q     <= sat_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      steps_d     = steps_q;
      aborted_d   = aborted_q;
      dir_n_d     = dir_n_q;
      cnt_ce_o    = 1'b0;
      cnt_clear_o = 1'b0;
`ifdef COUNTER_RUN_CTRL_SAT_EN
      sat_d       = sat_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) begin
               len_d     = cmd_len_i;
               dir_n_d   = ~cmd_dir_i;
               steps_d   = 8'd0;
               aborted_d = 1'b0;
`ifdef COUNTER_RUN_CTRL_SAT_EN
               sat_d     = 1'b0;
`endif
               if (cmd_clr_i)
                  state_d = S_CLEAR;
               else if (cmd_len_i != 8'd0)
                  state_d = S_RUN;
               else
                  state_d = S_DONE;
            end
         end
         S_CLEAR: begin
            if (abort_i) begin
               aborted_d = 1'b1;
               state_d   = S_DONE;
            end else begin
               cnt_clear_o = 1'b1;
               state_d     = (len_q != 8'd0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            // Abort outranks the saturation guard; both suppress CE this cycle.
            if (abort_i) begin
               aborted_d = 1'b1;
               state_d   = S_DONE;
            end
`ifdef COUNTER_RUN_CTRL_SAT_EN
            else if (sat_now) begin
               sat_d   = 1'b1;
               state_d = S_DONE;
            end
`endif
            else begin
               cnt_ce_o = 1'b1;
               steps_d  = steps_inc;
               if (steps_inc == len_q)
                  state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign cmd_ready_o  = (state_q == S_IDLE);
   assign busy_o       = (state_q == S_CLEAR) || (state_q == S_RUN);
   assign done_o       = (state_q == S_DONE);
   assign cnt_updown_o = ~dir_n_q;
   assign steps_done_o = steps_q;
   assign aborted_o    = aborted_q;
`ifdef COUNTER_RUN_CTRL_SAT_EN
   assign sat_hit_o    = sat_q;
`endif

endmodule

// File: tb/tb_counter_run_ctrl.sv
// tb/tb_counter_run_ctrl.sv - self-checking bench for counter_run_ctrl
module tb_counter_run_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_dir = 1'b0;
   logic [7:0] cmd_len = 8'd0;
   logic       cmd_clr = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] cnt;
   logic       cnt_ce, cnt_updown, cnt_clear;
   logic       busy, done, aborted;
   logic [7:0] steps_done;
   logic       preset_en = 1'b1;
   logic [7:0] preset_val = 8'd0;
`ifdef COUNTER_RUN_CTRL_SAT_EN
   logic       sat_hit;
`endif

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   counter_run_ctrl dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .cmd_valid_i  (cmd_valid),
      .cmd_ready_o  (cmd_ready),
      .cmd_dir_i    (cmd_dir),
      .cmd_len_i    (cmd_len),
      .cmd_clr_i    (cmd_clr),
      .abort_i      (abort),
      .cnt_value_i  (cnt),
      .cnt_ce_o     (cnt_ce),
      .cnt_updown_o (cnt_updown),
      .cnt_clear_o  (cnt_clear),
      .busy_o       (busy),
      .done_o       (done),
      .steps_done_o (steps_done),
      .aborted_o    (aborted)
`ifdef COUNTER_RUN_CTRL_SAT_EN
      ,
      .sat_hit_o    (sat_hit)
`endif
   );

   // The counter being sequenced (environment, not a reference model).
   always @(posedge clk) begin
      if (preset_en)
         cnt <= preset_val;
      else if (cnt_clear)
         cnt <= 8'd0;
      else if (cnt_ce)
         cnt <= cnt_updown ? cnt + 8'd1 : cnt - 8'd1;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic preset(input int v);
      @(negedge clk);
      preset_val = 8'(v);
      preset_en  = 1'b1;
      @(negedge clk);
      preset_en  = 1'b0;
   endtask

   // Reference model: walks the command step by step with plain arithmetic.
   task automatic predict(input int start, input bit dir, input int len, input bit clr,
                          input int abort_k, output int steps, output int ab,
                          output int sat, output int c, output int lat);
      int busy_cyc;
      c = start; busy_cyc = 0; steps = 0; ab = 0; sat = 0;
      if (clr) begin
         busy_cyc = 1;
         if (abort_k == 1) ab = 1;
         else c = 0;
      end
      for (int i = 1; i <= len && ab == 0 && sat == 0; i++) begin
         busy_cyc++;
         if (abort_k == int'(clr) + i) ab = 1;
`ifdef COUNTER_RUN_CTRL_SAT_EN
         else if (dir ? (c == 255) : (c == 0)) sat = 1;
`endif
         else begin
            c = dir ? (c + 1) % 256 : (c + 255) % 256;
            steps++;
         end
      end
      lat = busy_cyc + 1;
   endtask

   // Issues one command; abort_k is the cycle after accept (1 = first) to raise abort.
   task automatic run_cmd(input bit dir, input int len, input bit clr, input int abort_k,
                          output int o_ce, output int o_clr, output int o_lat,
                          output int o_steps, output int o_ab, output int o_sat,
                          output int o_cnt);
      int guard;
      int ready_bad;
      o_ce = 0; o_clr = 0; o_lat = -1; o_steps = 0; o_ab = 0; o_sat = 0; o_cnt = 0;
      ready_bad = 0;
      @(negedge clk);
      guard = 0;
      while (!cmd_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("ready_before_cmd", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_dir = dir; cmd_len = 8'(len); cmd_clr = clr;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int k = 1; k <= 600; k++) begin
         abort = (k == abort_k);
         @(negedge clk);
         if (done) begin
            o_lat = k; o_steps = steps_done; o_ab = aborted; o_cnt = cnt;
`ifdef COUNTER_RUN_CTRL_SAT_EN
            o_sat = sat_hit;
`endif
            if (cmd_ready) ready_bad = 1;
            break;
         end
         if (cnt_ce) o_ce++;
         if (cnt_clear) o_clr++;
         if (cmd_ready || !busy) ready_bad = 1;
         @(posedge clk); #1;
      end
      abort = 1'b0;
      chk("no_timeout", (o_lat > 0) ? 1 : 0, 1);
      chk("ready_low_busy_busy_high", ready_bad, 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("ready_after_done", cmd_ready, 1);
   endtask

   typedef struct {
      bit pre_en; int pre; bit dir; int len; bit clr; int abort_k;
      int e_steps; int e_ab; int e_sat; int e_cnt; int e_lat; int e_clr;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int o_ce, o_clr, o_lat, o_steps, o_ab, o_sat, o_cnt;
      int m_steps, m_ab, m_sat, m_cnt, m_lat, start, abort_k, len;
      bit dir, clr;
      int acc[$];
      int flag, ce_n;

      tbl[0] = '{1, 77, 1, 5, 1, 0,    5, 0, 0, 5, 7, 1};
      tbl[1] = '{1, 3, 0, 3, 0, 0,     3, 0, 0, 0, 4, 0};
`ifdef COUNTER_RUN_CTRL_SAT_EN
      tbl[2] = '{0, 0, 0, 1, 0, 0,     0, 0, 1, 0, 2, 0};
      tbl[3] = '{0, 0, 1, 0, 0, 0,     0, 0, 0, 0, 1, 0};
`else
      tbl[2] = '{0, 0, 0, 1, 0, 0,     1, 0, 0, 255, 2, 0};
      tbl[3] = '{0, 0, 1, 0, 0, 0,     0, 0, 0, 255, 1, 0};
`endif
      tbl[4] = '{0, 0, 1, 0, 1, 0,     0, 0, 0, 0, 2, 1};
      tbl[5] = '{0, 0, 1, 200, 0, 10,  9, 1, 0, 9, 11, 0};
`ifdef COUNTER_RUN_CTRL_SAT_EN
      tbl[6] = '{1, 254, 1, 3, 0, 0,   1, 0, 1, 255, 3, 0};
      tbl[8] = '{1, 100, 1, 255, 0, 0, 155, 0, 1, 255, 157, 0};
`else
      tbl[6] = '{1, 254, 1, 3, 0, 0,   3, 0, 0, 1, 4, 0};
      tbl[8] = '{1, 100, 1, 255, 0, 0, 255, 0, 0, 99, 256, 0};
`endif
      tbl[7] = '{1, 40, 0, 4, 1, 1,    0, 1, 0, 40, 2, 0};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_ce", cnt_ce, 0);
      chk("rst_clear", cnt_clear, 0);
      chk("rst_updown", cnt_updown, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_steps", steps_done, 0);
      chk("rst_aborted", aborted, 0);
`ifdef COUNTER_RUN_CTRL_SAT_EN
      chk("rst_sat", sat_hit, 0);
`endif
      rst_n = 1'b1;
      preset_en = 1'b0;

      // Directed table
      foreach (tbl[i]) begin
         if (tbl[i].pre_en) preset(tbl[i].pre);
         run_cmd(tbl[i].dir, tbl[i].len, tbl[i].clr, tbl[i].abort_k,
                 o_ce, o_clr, o_lat, o_steps, o_ab, o_sat, o_cnt);
         chk($sformatf("v%0d_ce", i), o_ce, tbl[i].e_steps);
         chk($sformatf("v%0d_clr", i), o_clr, tbl[i].e_clr);
         chk($sformatf("v%0d_lat", i), o_lat, tbl[i].e_lat);
         chk($sformatf("v%0d_steps", i), o_steps, tbl[i].e_steps);
         chk($sformatf("v%0d_aborted", i), o_ab, tbl[i].e_ab);
         chk($sformatf("v%0d_cnt", i), o_cnt, tbl[i].e_cnt);
`ifdef COUNTER_RUN_CTRL_SAT_EN
         chk($sformatf("v%0d_sat", i), o_sat, tbl[i].e_sat);
`endif
      end

      // Randomized commands against the model
      for (int r = 0; r < 30; r++) begin
         case ($urandom_range(0, 3))
            0: preset($urandom_range(0, 255));
            1: preset($urandom_range(0, 1) ? $urandom_range(250, 255) : $urandom_range(0, 5));
            default: ;
         endcase
         dir = 1'($urandom_range(0, 1));
         clr = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 9) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 30);
         abort_k = 0;
         if ($urandom_range(0, 2) == 0 && (len + int'(clr)) > 0)
            abort_k = $urandom_range(1, len + int'(clr));
         start = cnt;
         predict(start, dir, len, clr, abort_k, m_steps, m_ab, m_sat, m_cnt, m_lat);
         run_cmd(dir, len, clr, abort_k, o_ce, o_clr, o_lat, o_steps, o_ab, o_sat, o_cnt);
         chk($sformatf("r%0d_ce", r), o_ce, m_steps);
         chk($sformatf("r%0d_clr", r), o_clr, (clr && abort_k != 1) ? 1 : 0);
         chk($sformatf("r%0d_lat", r), o_lat, m_lat);
         chk($sformatf("r%0d_steps", r), o_steps, m_steps);
         chk($sformatf("r%0d_aborted", r), o_ab, m_ab);
         chk($sformatf("r%0d_cnt", r), o_cnt, m_cnt);
`ifdef COUNTER_RUN_CTRL_SAT_EN
         chk($sformatf("r%0d_sat", r), o_sat, m_sat);
`endif
      end

      // Back-to-back: valid held high, len=2
      preset(0);
      cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_len = 8'd2; cmd_clr = 1'b0;
      flag = 0; ce_n = 0;
      for (int c = 0; c <= 16; c++) begin
         if (cmd_valid && cmd_ready) acc.push_back(c);
         if ((busy || done) && cmd_ready) flag = 1;
         if (cnt_ce) ce_n++;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("b2b_accepts", acc.size(), 5);
      for (int i = 1; i < acc.size(); i++)
         if (acc[i] - acc[i-1] != 4) flag = 1;
      chk("b2b_spacing_ready", flag, 0);
      chk("b2b_ce", ce_n, 8);

      // Reset mid-run, then accept on the first edge after release
      cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_len = 8'd50; cmd_clr = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      chk("mid_ce_before", cnt_ce, 1);
      chk("mid_updown_before", cnt_updown, 0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ce", cnt_ce, 0);
      chk("mid_rst_clear", cnt_clear, 0);
      chk("mid_rst_updown", cnt_updown, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_steps", steps_done, 0);
      chk("mid_rst_aborted", aborted, 0);
      chk("mid_rst_ready", cmd_ready, 1);
      flag = 0;
      repeat (3) begin
         @(negedge clk);
         if (done || busy) flag = 1;
      end
      chk("mid_rst_no_done", flag, 0);
      cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_len = 8'd3; cmd_clr = 1'b1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("accept_first_edge", busy, 1);
      flag = 0;
      for (int k = 0; k < 20 && !done; k++) @(negedge clk);
      chk("post_rst_done", done, 1);
      chk("post_rst_steps", steps_done, 3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
